// File: rtl/instr_fetch_if.sv
// instr_fetch_if: pipelined in-order instruction bus.
// master = fetch stage (req/addr), slave = memory (ready/rvalid/rdata).
interface instr_fetch_if;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ready;
  logic        ibus_rvalid;
  logic [31:0] ibus_rdata;

  modport master (
    output ibus_req, ibus_addr,
    input  ibus_ready, ibus_rvalid, ibus_rdata
  );

  modport slave (
    input  ibus_req, ibus_addr,
    output ibus_ready, ibus_rvalid, ibus_rdata
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: IF stage, 2 outstanding bus reads, 2-deep response buffer.
// Ports: clk/rst, HDU stall/flush, EX redirect, ibus master, IF/ID register.
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_stall,
  input  logic          if_flush,
  input  logic          branch_take,
  input  logic [31:0]   branch_pc,
  instr_fetch_if.master ibus,
  output logic          if2id_valid,
  output logic [31:0]   if2id_pc,
  output logic [31:0]   if2id_instruction
);
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0] pc_q, pc_d;
  logic [1:0]  outst_q, outst_d;
  logic [1:0]  drop_q, drop_d;
  logic [31:0] pend_q [2];
  logic [31:0] pend_d [2];
  logic [31:0] bpc_q [2];
  logic [31:0] bpc_d [2];
  logic [31:0] bins_q [2];
  logic [31:0] bins_d [2];
  logic [1:0]  bcnt_q, bcnt_d;
  logic        v_q, v_d;
  logic [31:0] vpc_q, vpc_d;
  logic [31:0] vins_q, vins_d;

  logic [2:0] credit;
  logic       req, acc, rsp, drop, keep, adv;
  logic       pop, push, pidx, bidx;

  // credits cover both in-flight reads and buffered words,
  // so a kept response always has a buffer slot
  assign credit = {1'b0, outst_q} + {1'b0, bcnt_q};
  assign req  = ~rst & ~branch_take & (credit < 3'd2);
  assign acc  = req & ibus.ibus_ready;
  // a response with nothing outstanding is stale (e.g. across reset)
  assign rsp  = ibus.ibus_rvalid & (outst_q != 2'd0);
  assign drop = rsp & ((drop_q != 2'd0) | branch_take);
  assign keep = rsp & ~drop;
  assign adv  = ~if_stall & ~if_flush;

  assign ibus.ibus_req      = req;
  assign ibus.ibus_addr     = pc_q;
  assign if2id_valid        = v_q;
  assign if2id_pc           = vpc_q;
  assign if2id_instruction  = vins_q;

  always_comb begin
    pc_d = pc_q;
    if (branch_take)
      pc_d = branch_pc;
    else if (acc)
      pc_d = pc_q + 32'd4;

    outst_d = outst_q - {1'b0, rsp} + {1'b0, acc};

    pend_d = pend_q;
    pidx   = rsp ? 1'b0 : outst_q[0];
    if (rsp)
      pend_d[0] = pend_q[1];
    if (acc)
      pend_d[pidx] = pc_q;

    drop_d = drop_q;
    if (branch_take)
      drop_d = outst_q - {1'b0, rsp};
    else if (rsp && drop_q != 2'd0)
      drop_d = drop_q - 2'd1;

    v_d    = v_q;
    vpc_d  = vpc_q;
    vins_d = vins_q;
    pop    = 1'b0;
    push   = 1'b0;
    if (branch_take) begin
      // a stalled, unflushed instruction survives the redirect
      if (~if_stall | if_flush)
        v_d = 1'b0;
    end else if (~adv) begin
      push = keep;
      if (if_flush)
        v_d = 1'b0;
    end else if (bcnt_q != 2'd0) begin
      pop    = 1'b1;
      push   = keep;
      v_d    = 1'b1;
      vpc_d  = bpc_q[0];
      vins_d = bins_q[0];
    end else if (keep) begin
      v_d    = 1'b1;
      vpc_d  = pend_q[0];
      vins_d = ibus.ibus_rdata;
    end else begin
      v_d = 1'b0;
    end

    bpc_d  = bpc_q;
    bins_d = bins_q;
    bidx   = pop ? 1'b0 : bcnt_q[0];
    if (pop) begin
      bpc_d[0]  = bpc_q[1];
      bins_d[0] = bins_q[1];
    end
    if (push) begin
      bpc_d[bidx]  = pend_q[0];
      bins_d[bidx] = ibus.ibus_rdata;
    end
    bcnt_d = bcnt_q - {1'b0, pop} + {1'b0, push};
    if (branch_take)
      bcnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= RESET_VECTOR;
      outst_q   <= 2'd0;
      drop_q    <= 2'd0;
      pend_q[0] <= 32'd0;
      pend_q[1] <= 32'd0;
      bpc_q[0]  <= 32'd0;
      bpc_q[1]  <= 32'd0;
      bins_q[0] <= 32'd0;
      bins_q[1] <= 32'd0;
      bcnt_q    <= 2'd0;
      v_q       <= 1'b0;
      vpc_q     <= RESET_VECTOR;
      vins_q    <= NOP;
    end else begin
      pc_q    <= pc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
      pend_q  <= pend_d;
      bpc_q   <= bpc_d;
      bins_q  <= bins_d;
      bcnt_q  <= bcnt_d;
      v_q     <= v_d;
      vpc_q   <= vpc_d;
      vins_q  <= vins_d;
    end
  end
endmodule
